sad_addr_ctrl: RTL and testbench
================================

Name: sad_addr_ctrl

Overview:
- Controller and datapath for one Sum-of-Absolute-Differences pass over two pixel blocks A and B held in synchronous RAMs.
- Drives the shared AB_addr/AB_rd read port and applies the end-of-block test (addr < N_PIXELS) internally.
- Accumulates |A-B| and reports the SAD with a go/done handshake.
- Sits between the top-level sequencer and the A/B block memories.

Parameters:
- N_PIXELS, 256, pixels per block; must satisfy N_PIXELS <= 2^ADDR_W - 1.
- ADDR_W, 9, address width; one bit wider than the index range so the terminal value N_PIXELS is representable.
- DATA_W, 8, pixel width, unsigned.
- SUM_W, 16, accumulator width; must hold N_PIXELS*(2^DATA_W-1) = 65280 at defaults.
- THRESH, 1000, early-exit limit; used only with SAD_EARLY_EXIT_EN.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- go  in  1  start request; sampled only in IDLE
- A_data  in  DATA_W  A RAM read data; valid the cycle after the AB_rd/AB_addr cycle
- B_data  in  DATA_W  B RAM read data; same timing as A_data
- AB_addr  out  ADDR_W  shared read address, registered
- AB_rd  out  1  read strobe for both RAMs
- sad_out  out  SUM_W  result, registered; holds until the next done
- done  out  1  result valid; level, held until the next go is accepted
- early  out  1  pass ended by threshold; constant 0 without the macro

Behaviour:
- Reset: async on rst_n low. State=IDLE; AB_addr=0, AB_rd=0, sad_out=0, done=0, early=0; sum=0, rd_q=0.
- FSM states: IDLE, INIT, RUN.
- IDLE: go=1 moves to INIT. Clear done and early on the same edge.
- INIT: one cycle. sum<=0, AB_addr<=0, rd_q<=0. Next state is RUN.
- RUN issue:
  - AB_rd = (state==RUN) && (AB_addr < N_PIXELS), unsigned compare.
  - When AB_rd=1, AB_addr increments each cycle and stops at N_PIXELS.
  - AB_addr never wraps.
- RUN pipeline:
  - rd_q <= AB_rd.
  - When rd_q=1: sum <= sum + |A_data - B_data|.
  - Compute the difference as (a>=b) ? a-b : b-a at DATA_W bits.
  - Zero-extend the difference to SUM_W. No saturation is needed, given the SUM_W rule.
- RUN exit:
  - Condition: AB_addr==N_PIXELS and rd_q==0.
  - On that edge: sad_out<=sum, done<=1, state=IDLE.
- Latency at defaults: go sampled at edge 1; 256 reads on edges 3..258; last accumulate at edge 259; done=1 after edge 260.
- go in INIT or RUN is ignored. No restart, no queuing.
- go in IDLE while done=1 starts a new pass. done falls on the accepting edge.
- Reset mid-pass: abort immediately to reset values. No partial result is kept.

Optional Feature:
- Macro: SAD_EARLY_EXIT_EN.
- Defined:
  - In RUN, AB_rd is additionally gated by (sum <= THRESH), using registered sum.
  - The at most one in-flight read still accumulates.
  - Exit condition becomes rd_q==0 && (AB_addr==N_PIXELS || sum>THRESH).
  - early<=1 if the pass ended with sum>THRESH.
- Undefined: threshold logic is absent; early is tied 0; THRESH is unused.

Decomposition:
- Package sad_pkg holds:
  - state enum {IDLE, INIT, RUN};
  - default localparams for N_PIXELS, ADDR_W, DATA_W, SUM_W;
  - a function computing the minimum SUM_W, for an elaboration check.
- Sub-module sad_absdiff: combinational |a-b| at DATA_W. It is also reusable by a future parallel SAD.
- Keep FSM, counter and accumulator in the top module.

Test Plan:
1. All A=B=0x5A, pulse go → 256 AB_rd pulses, addresses 0..255; done after edge 260; sad_out=0; early=0.
2. A=255, B=0 everywhere → sad_out=65280 (0xFF00); AB_addr parks at 256; AB_rd=0 after the last read.
3. A[i]=i, B[i]=255-i → sad_out=32768.
4. Pulse go mid-RUN at address 100 → ignored, result unchanged. Then go while done=1 → done drops on the accept edge, second pass gives the identical result.
5. rst_n low at address 100, for an arbitrary fraction of a cycle → all outputs 0 asynchronously. Next go gives the correct full result.
6. With SAD_EARLY_EXIT_EN, THRESH=1000, A=255, B=0 → 5 reads issued (addresses 0..4); sad_out=1275; early=1. Without the macro the same stimulus gives 65280 and early=0.

Source files
------------

// File: rtl/sad_pkg.sv
// Shared types and defaults for the SAD address controller slice.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
package sad_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2
    } sad_state_t;

    localparam int SAD_N_PIXELS = 256;
    localparam int SAD_ADDR_W   = 9;
    localparam int SAD_DATA_W   = 8;
    localparam int SAD_SUM_W    = 16;
    localparam int SAD_THRESH   = 1000;

    // Smallest accumulator width that holds n_pixels * (2^data_w - 1).
    function automatic int sad_min_sum_w(input int n_pixels, input int data_w);
        longint max_sum;
        max_sum = longint'(n_pixels) * ((longint'(1) << data_w) - 1);
        return $clog2(max_sum + 1);
    endfunction

endpackage

// File: rtl/sad_addr_ctrl_if.sv
// Bundles the sequencer handshake (go/done/sad_out/early) and the A/B RAM read port.
// Latency: n/a (wiring only).
// Backpressure: none; go is only sampled while the controller is idle.
// slave  : the controller (drives address/strobe/result, receives go and RAM data)
// master : the sequencer + RAM side
interface sad_addr_ctrl_if
    import sad_pkg::*;
#(
    parameter int ADDR_W = SAD_ADDR_W,
    parameter int DATA_W = SAD_DATA_W,
    parameter int SUM_W  = SAD_SUM_W
);
    logic              go;
    logic [DATA_W-1:0] A_data;
    logic [DATA_W-1:0] B_data;
    logic [ADDR_W-1:0] AB_addr;
    logic              AB_rd;
    logic [SUM_W-1:0]  sad_out;
    logic              done;
    logic              early;

    modport slave (
        input  go, A_data, B_data,
        output AB_addr, AB_rd, sad_out, done, early
    );

    modport master (
        output go, A_data, B_data,
        input  AB_addr, AB_rd, sad_out, done, early
    );
endinterface

// File: rtl/sad_absdiff.sv
// Unsigned absolute difference |a - b| at the pixel width.
// Latency: combinational.
// Backpressure: none.
// Ports: a, b (DATA_W unsigned in); diff (DATA_W out).
module sad_absdiff #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] diff
);
    // Subtract the smaller from the larger so the result never needs a sign bit.
    assign diff = (a >= b) ? (a - b) : (b - a);
endmodule

// File: rtl/sad_addr_ctrl.sv
// One SAD pass over blocks A/B: drives the shared RAM read port, accumulates |A-B|, reports via go/done.
// Latency: done rises N_PIXELS+4 edges after the go-accepting edge counts as edge 1 (edge 260 at defaults).
// Backpressure: none; go is ignored outside IDLE, done is a level held until the next go is accepted.
// Ports: clk, rst_n (async active-low); bus (sad_addr_ctrl_if.slave): go, A_data, B_data in;
//        AB_addr, AB_rd, sad_out, done, early out.
// Optional build macro SAD_EARLY_EXIT_EN: stop issuing reads once the running sum exceeds THRESH.
module sad_addr_ctrl
    import sad_pkg::*;
#(
    parameter int N_PIXELS = SAD_N_PIXELS,
    parameter int ADDR_W   = SAD_ADDR_W,
    parameter int DATA_W   = SAD_DATA_W,
    parameter int SUM_W    = SAD_SUM_W,
    parameter int THRESH   = SAD_THRESH
) (
    input  logic            clk,
    input  logic            rst_n,
    sad_addr_ctrl_if.slave  bus
);

    // Parameter sanity: the terminal address must fit, and the sum must never overflow.
    if (N_PIXELS > (1 << ADDR_W) - 1) begin : g_bad_addr_w
        $error("sad_addr_ctrl: ADDR_W too narrow for N_PIXELS");
    end
    if (SUM_W < sad_min_sum_w(N_PIXELS, DATA_W)) begin : g_bad_sum_w
        $error("sad_addr_ctrl: SUM_W too narrow for N_PIXELS*(2^DATA_W-1)");
    end
    if (THRESH < 0) begin : g_bad_thresh
        $error("sad_addr_ctrl: THRESH must be non-negative");
    end

    localparam logic [ADDR_W-1:0] ADDR_END = ADDR_W'(N_PIXELS);

    sad_state_t        state;
    logic [ADDR_W-1:0] addr_q;
    logic [SUM_W-1:0]  sum_q;
    logic [SUM_W-1:0]  sad_q;
    logic              rd_q;
    logic              done_q;
    logic [DATA_W-1:0] diff;
    logic              rd_en;
    logic              pass_end;

    sad_absdiff #(.DATA_W(DATA_W)) u_absdiff (
        .a    (bus.A_data),
        .b    (bus.B_data),
        .diff (diff)
    );

`ifdef SAD_EARLY_EXIT_EN
    localparam logic [SUM_W-1:0] THRESH_V = SUM_W'(THRESH);

    logic over_thresh;
    logic early_q;

    // Registered sum gates issue, so at most one read is already in flight when the limit trips.
    assign over_thresh = (sum_q > THRESH_V);
    assign rd_en       = (state == RUN) && (addr_q < ADDR_END) && !over_thresh;
    assign pass_end    = !rd_q && ((addr_q == ADDR_END) || over_thresh);
    assign bus.early   = early_q;
`else
    assign rd_en       = (state == RUN) && (addr_q < ADDR_END);
    assign pass_end    = !rd_q && (addr_q == ADDR_END);
    assign bus.early   = 1'b0;
`endif

    assign bus.AB_rd   = rd_en;
    assign bus.AB_addr = addr_q;
    assign bus.sad_out = sad_q;
    assign bus.done    = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            addr_q  <= '0;
            sum_q   <= '0;
            sad_q   <= '0;
            rd_q    <= 1'b0;
            done_q  <= 1'b0;
`ifdef SAD_EARLY_EXIT_EN
            early_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.go) begin
                        state   <= INIT;
                        done_q  <= 1'b0;
`ifdef SAD_EARLY_EXIT_EN
                        early_q <= 1'b0;
`endif
                    end
                end
                INIT: begin
                    sum_q  <= '0;
                    addr_q <= '0;
                    rd_q   <= 1'b0;
                    state  <= RUN;
                end
                RUN: begin
                    // rd_q marks that RAM data for the previous address is on A_data/B_data now.
                    rd_q <= rd_en;
                    if (rd_en) begin
                        addr_q <= addr_q + 1'b1;
                    end
                    if (rd_q) begin
                        sum_q <= sum_q + SUM_W'(diff);
                    end
                    // Exit only once the pipeline has drained, so sum_q is final here.
                    if (pass_end) begin
                        sad_q   <= sum_q;
                        done_q  <= 1'b1;
                        state   <= IDLE;
`ifdef SAD_EARLY_EXIT_EN
                        early_q <= over_thresh;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sad_addr_ctrl.sv
// Directed bench for sad_addr_ctrl with behavioural synchronous A/B RAMs.
// Latency: n/a.
// Backpressure: n/a.
module tb_sad_addr_ctrl;
    import sad_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   rd_count;
    int   addr_bad;

    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];

    sad_addr_ctrl_if bus ();

    sad_addr_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAMs: data appears the cycle after the AB_rd/AB_addr cycle.
    always @(posedge clk) begin
        if (bus.AB_rd) begin
            bus.A_data <= mem_a[bus.AB_addr[7:0]];
            bus.B_data <= mem_b[bus.AB_addr[7:0]];
        end
    end

    // Read monitor: the n-th strobe of a pass must carry address n.
    always @(negedge clk) begin
        if (rst_n && bus.AB_rd) begin
            if (bus.AB_addr != 9'(rd_count)) addr_bad++;
            rd_count++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Edge 1 is the go-accepting edge; done must rise exactly on done_edge.
    // poke_addr >= 0 pulses go for one cycle once AB_addr reaches that value.
    task automatic run_pass(input string tag, input int exp_sad, input int exp_early,
                            input int exp_reads, input int done_edge, input int poke_addr);
        bit poked;
        poked    = 0;
        rd_count = 0;
        addr_bad = 0;
        @(negedge clk);
        bus.go = 1'b1;
        @(posedge clk);
        #1;
        bus.go = 1'b0;
        chk({tag, " done low after accept"}, 32'(bus.done), 32'd0);
        for (int e = 2; e < done_edge; e++) begin
            @(posedge clk);
            #1;
            if (bus.go) bus.go = 1'b0;
            if (poke_addr >= 0 && !poked && bus.AB_addr == 9'(poke_addr)) begin
                bus.go = 1'b1;
                poked  = 1;
            end
        end
        bus.go = 1'b0;
        chk({tag, " done low before final edge"}, 32'(bus.done), 32'd0);
        @(posedge clk);
        #1;
        chk({tag, " done high on final edge"}, 32'(bus.done), 32'd1);
        chk({tag, " sad_out"}, 32'(bus.sad_out), 32'(exp_sad));
        chk({tag, " early"}, 32'(bus.early), 32'(exp_early));
        chk({tag, " read count"}, 32'(rd_count), 32'(exp_reads));
        chk({tag, " address order"}, 32'(addr_bad), 32'd0);
        chk({tag, " AB_addr parked"}, 32'(bus.AB_addr), 32'(exp_reads));
        chk({tag, " AB_rd idle"}, 32'(bus.AB_rd), 32'd0);
        if (poke_addr >= 0) chk({tag, " go poked mid-run"}, 32'(poked), 32'd1);
    endtask

    initial begin
        bit seen;
        checks   = 0;
        errors   = 0;
        rd_count = 0;
        addr_bad = 0;
        rst_n    = 1'b0;
        bus.go   = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 8'h5A;
            mem_b[i] = 8'h5A;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("reset AB_addr", 32'(bus.AB_addr), 32'd0);
        chk("reset AB_rd", 32'(bus.AB_rd), 32'd0);
        chk("reset sad_out", 32'(bus.sad_out), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        chk("reset early", 32'(bus.early), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: identical blocks give zero.
        run_pass("equal", 0, 0, 256, 260, -1);

`ifndef SAD_EARLY_EXIT_EN
        // 2: maximum difference everywhere.
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 8'd255;
            mem_b[i] = 8'd0;
        end
        run_pass("max", 65280, 0, 256, 260, -1);

        // 3: ramps in opposite directions, sum of |2i-255| = 32768.
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 8'(i);
            mem_b[i] = 8'(255 - i);
        end
        run_pass("ramp", 32768, 0, 256, 260, -1);

        // 4: go mid-run is ignored; go while done restarts with identical result.
        run_pass("go midrun", 32768, 0, 256, 260, 100);
        run_pass("restart", 32768, 0, 256, 260, -1);

        // 5: asynchronous reset mid-pass, then a clean full pass.
        rd_count = 0;
        @(negedge clk);
        bus.go = 1'b1;
        @(posedge clk);
        #1;
        bus.go = 1'b0;
        seen = 0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (bus.AB_addr == 9'd100) seen = 1;
        end
        chk("midreset reached addr 100", 32'(seen), 32'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset AB_addr", 32'(bus.AB_addr), 32'd0);
        chk("midreset AB_rd", 32'(bus.AB_rd), 32'd0);
        chk("midreset sad_out", 32'(bus.sad_out), 32'd0);
        chk("midreset done", 32'(bus.done), 32'd0);
        chk("midreset early", 32'(bus.early), 32'd0);
        #1;
        rst_n = 1'b1;
        run_pass("after reset", 32768, 0, 256, 260, -1);
`endif

        // 6: threshold stimulus; early exit after 5 reads only when the feature is built in.
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 8'd255;
            mem_b[i] = 8'd0;
        end
`ifdef SAD_EARLY_EXIT_EN
        run_pass("thresh", 1275, 1, 5, 9, -1);
`else
        run_pass("thresh", 65280, 0, 256, 260, -1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
